// File: rtl/led_pwm_palette_driver_if.sv
// Bundle of palette duty inputs, run enable and PWM LED outputs between the
// palette pulser (master) and the PWM driver (slave).
interface led_pwm_palette_driver_if #(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4
);
  logic                              i_enable;
  logic [8*parm_color_led_count-1:0] i_color_led_red_value;
  logic [8*parm_color_led_count-1:0] i_color_led_green_value;
  logic [8*parm_color_led_count-1:0] i_color_led_blue_value;
  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value;
  logic [parm_color_led_count-1:0]   eo_color_led_red;
  logic [parm_color_led_count-1:0]   eo_color_led_green;
  logic [parm_color_led_count-1:0]   eo_color_led_blue;
  logic [parm_basic_led_count-1:0]   eo_basic_led;
  logic                              o_period_strobe;

  modport master (
    output i_enable, i_color_led_red_value, i_color_led_green_value,
           i_color_led_blue_value, i_basic_led_lumin_value,
    input  eo_color_led_red, eo_color_led_green, eo_color_led_blue,
           eo_basic_led, o_period_strobe
  );

  modport slave (
    input  i_enable, i_color_led_red_value, i_color_led_green_value,
           i_color_led_blue_value, i_basic_led_lumin_value,
    output eo_color_led_red, eo_color_led_green, eo_color_led_blue,
           eo_basic_led, o_period_strobe
  );
endinterface

// File: rtl/led_pwm_palette_driver.sv
// 255-step PWM driver for RGB and basic LEDs with per-period shadowed duties
// and per-LED phase staggering to spread switching edges.
module led_pwm_palette_driver #(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_pwm_freq_hz     = 1000,
  parameter int parm_phase_step      = 64
) (
  input  logic i_clk,
  input  logic i_arst_n,
  led_pwm_palette_driver_if.slave bus
);
  localparam int NC      = parm_color_led_count;
  localparam int NB      = parm_basic_led_count;
  localparam int c_div   = parm_FCLK / (parm_pwm_freq_hz * 255);
  localparam int c_pre_w = (c_div > 1) ? $clog2(c_div) : 1;

  generate
    if (c_div < 1) begin : g_bad_div
      $error("led_pwm_palette_driver: clock too slow for requested PWM rate (c_div < 1)");
    end
  endgenerate

  logic [c_pre_w-1:0] pre;
  logic [7:0]         s_step;
  logic               s_ce;
  logic               s_wrap;
  logic               strobe_q;

  logic [8*NC-1:0] sh_red, sh_green, sh_blue;
  logic [8*NB-1:0] sh_lumin;

  logic [NC-1:0] red_on, green_on, blue_on;
  logic [NB-1:0] basic_on;
  logic [NC-1:0] red_q, green_q, blue_q;
  logic [NB-1:0] basic_q;

  assign s_ce   = bus.i_enable && (pre == c_pre_w'(c_div - 1));
  assign s_wrap = s_ce && (s_step == 8'd254);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pre      <= '0;
      s_step   <= '0;
      strobe_q <= 1'b0;
    end else if (!bus.i_enable) begin
      pre      <= '0;
      s_step   <= '0;
      strobe_q <= 1'b0;
    end else begin
      pre      <= s_ce ? '0 : pre + c_pre_w'(1);
      strobe_q <= s_wrap;
      if (s_ce) begin
        s_step <= s_wrap ? 8'd0 : s_step + 8'd1;
      end
    end
  end

  // Shadows track the inputs while idle so a restart uses the latest duties.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sh_red   <= '0;
      sh_green <= '0;
      sh_blue  <= '0;
      sh_lumin <= '0;
    end else if (!bus.i_enable || s_wrap) begin
      sh_red   <= bus.i_color_led_red_value;
      sh_green <= bus.i_color_led_green_value;
      sh_blue  <= bus.i_color_led_blue_value;
      sh_lumin <= bus.i_basic_led_lumin_value;
    end
  end

  function automatic logic [7:0] phase_of(input logic [7:0] step, input logic [7:0] offset);
    logic [8:0] sum;
    sum = {1'b0, step} + {1'b0, offset};
    if (sum >= 9'd255) sum = sum - 9'd255;
    return sum[7:0];
  endfunction

  generate
    for (genvar k = 0; k < NC; k++) begin : g_color
      localparam logic [7:0] c_off = 8'((k * parm_phase_step) % 255);
      logic [7:0] p;
      assign p           = phase_of(s_step, c_off);
      assign red_on[k]   = p < sh_red[8*k +: 8];
      assign green_on[k] = p < sh_green[8*k +: 8];
      assign blue_on[k]  = p < sh_blue[8*k +: 8];
    end
    for (genvar k = 0; k < NB; k++) begin : g_basic
      localparam logic [7:0] c_off = 8'((k * parm_phase_step) % 255);
      logic [7:0] p;
      assign p           = phase_of(s_step, c_off);
      assign basic_on[k] = p < sh_lumin[8*k +: 8];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      basic_q <= '0;
    end else if (!bus.i_enable) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      basic_q <= '0;
    end else begin
      red_q   <= red_on;
      green_q <= green_on;
      blue_q  <= blue_on;
      basic_q <= basic_on;
    end
  end

  assign bus.eo_color_led_red   = red_q;
  assign bus.eo_color_led_green = green_q;
  assign bus.eo_color_led_blue  = blue_q;
  assign bus.eo_basic_led       = basic_q;
  assign bus.o_period_strobe    = strobe_q;
endmodule
